// File: rtl/pdly_pkg.sv
// rtl/pdly_pkg.sv - shared constants and tick conversion for the pdly delay-timer bank
package pdly_pkg;

    localparam int CLK_NS        = 20;
    localparam int PDLY_CHANNELS = 4;
    localparam int PDLY_WIDTH    = 8;

    // Legacy modules quoted delays in ns; round to the nearest tick, never below one.
    function automatic int ns_to_ticks(input int ns);
        int t;
        t = (ns + CLK_NS / 2) / CLK_NS;
        return (t < 1) ? 1 : t;
    endfunction

endpackage

// File: rtl/pdly_chan.sv
// rtl/pdly_chan.sv - one retriggerable delay channel; overrun flag under PDLY_OVERRUN_EN
module pdly_chan
    import pdly_pkg::*;
#(
    parameter int WIDTH  = PDLY_WIDTH,
    parameter int RETRIG = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cancel,
    input  logic [WIDTH-1:0] dly,
`ifdef PDLY_OVERRUN_EN
    input  logic             ovr_clr,
    output logic             ovr,
`endif
    output logic             p,
    output logic             l
);

    logic             busy;
    logic [WIDTH-1:0] cnt;
    logic             p_cycle;
    logic             dly_nz;
    logic             accept;

    assign p_cycle = busy && (cnt == WIDTH'(1));
    assign dly_nz  = (dly != '0);
    // A start in the expiry cycle always chains, whatever RETRIG says.
    assign accept  = start && dly_nz && (!busy || p_cycle || (RETRIG != 0));

    assign p = p_cycle;
    assign l = busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (accept) begin
            busy <= 1'b1;
            cnt  <= dly;
        end else if (cancel) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (busy) begin
            cnt <= cnt - WIDTH'(1);
            if (p_cycle) begin
                busy <= 1'b0;
            end
        end
    end

`ifdef PDLY_OVERRUN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovr <= 1'b0;
        end else if (start && dly_nz && busy && !p_cycle) begin
            ovr <= 1'b1;
        end else if (ovr_clr) begin
            ovr <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/pdly_bank.sv
// rtl/pdly_bank.sv - bank of independent delay timers; ovr/ovr_clr present under PDLY_OVERRUN_EN
module pdly_bank
    import pdly_pkg::*;
#(
    parameter int CHANNELS = PDLY_CHANNELS,
    parameter int WIDTH    = PDLY_WIDTH,
    parameter int RETRIG   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       cancel,
    input  logic [CHANNELS*WIDTH-1:0] dly,
`ifdef PDLY_OVERRUN_EN
    input  logic                      ovr_clr,
    output logic [CHANNELS-1:0]       ovr,
`endif
    output logic [CHANNELS-1:0]       p,
    output logic [CHANNELS-1:0]       l
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        pdly_chan #(
            .WIDTH  (WIDTH),
            .RETRIG (RETRIG)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .start   (start[i]),
            .cancel  (cancel[i]),
            .dly     (dly[i*WIDTH +: WIDTH]),
`ifdef PDLY_OVERRUN_EN
            .ovr_clr (ovr_clr),
            .ovr     (ovr[i]),
`endif
            .p       (p[i]),
            .l       (l[i])
        );
    end

endmodule

// File: tb/tb_pdly_bank.sv
// tb/tb_pdly_bank.sv - directed bench for pdly_bank (RETRIG=1 and RETRIG=0 instances)
module tb_pdly_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  start;
    logic [3:0]  cancel;
    logic [31:0] dly;
    logic [3:0]  p, l, p_nr, l_nr;
`ifdef PDLY_OVERRUN_EN
    logic        ovr_clr;
    logic [3:0]  ovr, ovr_nr;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pdly_bank #(.CHANNELS(4), .WIDTH(8), .RETRIG(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .cancel  (cancel),
        .dly     (dly),
`ifdef PDLY_OVERRUN_EN
        .ovr_clr (ovr_clr),
        .ovr     (ovr),
`endif
        .p       (p),
        .l       (l)
    );

    pdly_bank #(.CHANNELS(4), .WIDTH(8), .RETRIG(0)) dut_nr (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .cancel  (cancel),
        .dly     (dly),
`ifdef PDLY_OVERRUN_EN
        .ovr_clr (ovr_clr),
        .ovr     (ovr_nr),
`endif
        .p       (p_nr),
        .l       (l_nr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        start  = '0;
        cancel = '0;
        for (int k = 0; k < n; k++) next_cycle();
    endtask

    initial begin
        reset  = 1'b1;
        start  = '0;
        cancel = '0;
        dly    = '0;
`ifdef PDLY_OVERRUN_EN
        ovr_clr = 1'b0;
`endif
        next_cycle();
        next_cycle();
        chk("reset_l", {28'd0, l}, 32'd0);
        chk("reset_p", {28'd0, p}, 32'd0);
`ifdef PDLY_OVERRUN_EN
        chk("reset_ovr", {28'd0, ovr}, 32'd0);
`endif
        reset = 1'b0;
        idle(10);

        // ch0 D=5: l in 1..5, p only in 5
        for (int c = 0; c <= 7; c++) begin
            start = (c == 0) ? 4'b0001 : 4'b0000;
            if (c == 0) dly[0 +: 8] = 8'd5;
            chk("t1_l0", {31'd0, l[0]}, (c >= 1 && c <= 5) ? 32'd1 : 32'd0);
            chk("t1_p0", {31'd0, p[0]}, (c == 5) ? 32'd1 : 32'd0);
            next_cycle();
        end
        idle(3);

        // ch1 D=10, retrigger D=3 in cycle 4
        for (int c = 0; c <= 12; c++) begin
            start = (c == 0 || c == 4) ? 4'b0010 : 4'b0000;
            dly[8 +: 8] = (c == 0) ? 8'd10 : 8'd3;
            chk("t2_l1_retrig", {31'd0, l[1]}, (c >= 1 && c <= 7) ? 32'd1 : 32'd0);
            chk("t2_p1_retrig", {31'd0, p[1]}, (c == 7) ? 32'd1 : 32'd0);
            chk("t2_l1_noretrig", {31'd0, l_nr[1]}, (c >= 1 && c <= 10) ? 32'd1 : 32'd0);
            chk("t2_p1_noretrig", {31'd0, p_nr[1]}, (c == 10) ? 32'd1 : 32'd0);
`ifdef PDLY_OVERRUN_EN
            chk("t2_ovr1_retrig", {31'd0, ovr[1]}, (c >= 5) ? 32'd1 : 32'd0);
            chk("t2_ovr1_noretrig", {31'd0, ovr_nr[1]}, (c >= 5) ? 32'd1 : 32'd0);
`endif
            next_cycle();
        end
`ifdef PDLY_OVERRUN_EN
        ovr_clr = 1'b1;
        next_cycle();
        ovr_clr = 1'b0;
        chk("ovr_clr", {28'd0, ovr}, 32'd0);
`endif
        idle(3);

        // ch2 D=4, chained D=2 start in the p cycle
        for (int c = 0; c <= 8; c++) begin
            start = (c == 0 || c == 4) ? 4'b0100 : 4'b0000;
            dly[16 +: 8] = (c == 0) ? 8'd4 : 8'd2;
            chk("t3_l2", {31'd0, l[2]}, (c >= 1 && c <= 6) ? 32'd1 : 32'd0);
            chk("t3_p2", {31'd0, p[2]}, (c == 4 || c == 6) ? 32'd1 : 32'd0);
            chk("t3_l2_nr", {31'd0, l_nr[2]}, (c >= 1 && c <= 6) ? 32'd1 : 32'd0);
            chk("t3_p2_nr", {31'd0, p_nr[2]}, (c == 4 || c == 6) ? 32'd1 : 32'd0);
            next_cycle();
        end
`ifdef PDLY_OVERRUN_EN
        chk("t3_ovr2", {31'd0, ovr[2]}, 32'd0);
`endif
        idle(3);

        // ch3 D=8 cancelled in cycle 3
        for (int c = 0; c <= 10; c++) begin
            start  = (c == 0) ? 4'b1000 : 4'b0000;
            cancel = (c == 3) ? 4'b1000 : 4'b0000;
            dly[24 +: 8] = 8'd8;
            chk("t4_l3", {31'd0, l[3]}, (c >= 1 && c <= 3) ? 32'd1 : 32'd0);
            chk("t4_p3", {31'd0, p[3]}, 32'd0);
            next_cycle();
        end
        idle(2);

        // ch3 D=2 cancelled in its p cycle
        for (int c = 0; c <= 4; c++) begin
            start  = (c == 0) ? 4'b1000 : 4'b0000;
            cancel = (c == 2) ? 4'b1000 : 4'b0000;
            dly[24 +: 8] = 8'd2;
            chk("t4b_l3", {31'd0, l[3]}, (c >= 1 && c <= 2) ? 32'd1 : 32'd0);
            chk("t4b_p3", {31'd0, p[3]}, (c == 2) ? 32'd1 : 32'd0);
            next_cycle();
        end
        idle(2);

        // ch0 D=255, ch1 D=1, ch2 D=0; D=0 start on busy ch0 at cycle 100
        for (int c = 0; c <= 257; c++) begin
            start = (c == 0) ? 4'b0111 : ((c == 100) ? 4'b0001 : 4'b0000);
            dly[0 +: 8]  = (c == 0) ? 8'd255 : 8'd0;
            dly[8 +: 8]  = 8'd1;
            dly[16 +: 8] = 8'd0;
            chk("t5_l0", {31'd0, l[0]}, (c >= 1 && c <= 255) ? 32'd1 : 32'd0);
            chk("t5_p0", {31'd0, p[0]}, (c == 255) ? 32'd1 : 32'd0);
            chk("t5_l1", {31'd0, l[1]}, (c == 1) ? 32'd1 : 32'd0);
            chk("t5_p1", {31'd0, p[1]}, (c == 1) ? 32'd1 : 32'd0);
            chk("t5_lp2_d0", {30'd0, l[2], p[2]}, 32'd0);
`ifdef PDLY_OVERRUN_EN
            chk("t5_ovr0_d0", {31'd0, ovr[0]}, 32'd0);
`endif
            next_cycle();
        end
        idle(2);

        // ch0 D=6 (retriggered D=6 in cycle 1), reset held cycles 3..4
        for (int c = 0; c <= 12; c++) begin
            start = (c == 0 || c == 1) ? 4'b0001 : 4'b0000;
            dly[0 +: 8] = 8'd6;
            if (c == 3) reset = 1'b1;
            if (c == 5) reset = 1'b0;
            #1;
            chk("t6_l0", {31'd0, l[0]}, (c >= 1 && c <= 2) ? 32'd1 : 32'd0);
            chk("t6_p0", {31'd0, p[0]}, 32'd0);
`ifdef PDLY_OVERRUN_EN
            chk("t6_ovr0", {31'd0, ovr[0]}, (c == 2) ? 32'd1 : 32'd0);
`endif
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
